timer_periodic: RTL and testbench

Programmable, parametrised successor to the fixed 1 ms tick timer. It divides the system clock into a free-running base tick, then counts a programmable number of base ticks to produce expiry pulses. Expiry runs in one-shot or periodic mode, with start, stop and pause (enable) control. It sits between the game control FSM and the clock/reset tree, and provides level-speed, countdown and display-refresh timing.

---
 rtl/timer_periodic_if.sv | 30 +++
 rtl/timer_periodic.sv | 128 ++++++++++++
 tb/tb_timer_periodic.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_periodic_if.sv
// timer_periodic control/status bundle.
// master drives control, slave is the timer.
interface timer_periodic_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic             Start;
  logic             Stop;
  logic             Mode;
  logic [CNT_W-1:0] Period;
  logic             BaseTick;
  logic             Expire;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Remaining;

  modport master (
    output Enable, Start, Stop,
    output Mode, Period,
    input  BaseTick, Expire, Busy,
    input  Done, Remaining
  );

  modport slave (
    input  Enable, Start, Stop,
    input  Mode, Period,
    output BaseTick, Expire, Busy,
    output Done, Remaining
  );
endinterface

// File: rtl/timer_periodic.sv
// Prescaled base tick plus one-shot/periodic
// countdown with start, stop and pause control.
module timer_periodic #(
  parameter int CLK_HZ  = 50000000,
  parameter int BASE_US = 1000,
  parameter int CNT_W   = 16
) (
  input  logic Clk,
  input  logic Rst,
  timer_periodic_if.slave tif
);

  localparam int PRESCALE =
    CLK_HZ / 1000000 * BASE_US;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("timer_periodic: PRESCALE < 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             exp_q, exp_d;
  logic             tick_q;

  logic wrap;
  logic do_stop;
  logic do_load;
  logic do_tick;

  assign wrap    = tif.Enable && (pre_q == PMAX);
  assign do_stop = tif.Stop;
  assign do_load = tif.Start && !tif.Stop &&
                   (tif.Period != '0);
  assign do_tick = (state_q == RUN) && wrap &&
                   !do_stop && !do_load;

  // A loaded Start realigns the tick phase.
  always_comb begin
    pre_d = pre_q;
    if (do_load)
      pre_d = '0;
    else if (wrap)
      pre_d = '0;
    else if (tif.Enable)
      pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
      tick_q  <= wrap;
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    done_d  = done_q;
    exp_d   = 1'b0;
    unique case (1'b1)
      do_stop: begin
        state_d = IDLE;
        rem_d   = '0;
        done_d  = 1'b0;
      end
      do_load: begin
        state_d = RUN;
        per_d   = tif.Period;
        mode_d  = tif.Mode;
        rem_d   = tif.Period;
        done_d  = 1'b0;
      end
      do_tick: begin
        if (rem_q > CNT_W'(1)) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          exp_d = 1'b1;
          if (mode_q) begin
            rem_d = per_q;
          end else begin
            rem_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tif.Busy      = (state_q == RUN);
    tif.BaseTick  = tick_q;
    tif.Expire    = exp_q;
    tif.Done      = done_q;
    tif.Remaining = rem_q;
  end

endmodule

// File: tb/tb_timer_periodic.sv
// Scoreboard bench for timer_periodic:
// expected Expire cycles queued at Start.
module tb_timer_periodic;

  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   exp_q[$];

  timer_periodic_if #(.CNT_W(CNT_W)) ifc ();

  timer_periodic #(
    .CLK_HZ (1000000),
    .BASE_US(4),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk(clk),
    .Rst(rst_n),
    .tif(ifc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_vec = 0;
    n_bad = 0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @cyc %0d",
               tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.Expire === 1'b1) begin
      if (exp_q.size() == 0)
        chk("unexpected_expire", cyc, 32'hffff_ffff);
      else
        chk("expire_cyc", cyc, exp_q.pop_front());
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(input int p, input bit m,
                       output int n);
    @(negedge clk);
    ifc.Start  = 1'b1;
    ifc.Period = CNT_W'(p);
    ifc.Mode   = m;
    n = cyc + 1;
    @(negedge clk);
    ifc.Start = 1'b0;
  endtask

  task automatic stop_at(input int c);
    wait_to(c - 1);
    ifc.Stop = 1'b1;
    @(negedge clk);
    ifc.Stop = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, r;
    rst_n      = 1'b0;
    ifc.Enable = 1'b0;
    ifc.Start  = 1'b0;
    ifc.Stop   = 1'b0;
    ifc.Mode   = 1'b0;
    ifc.Period = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", ifc.Busy, 0);
    chk("rst_done", ifc.Done, 0);
    chk("rst_rem", ifc.Remaining, 0);
    chk("rst_expire", ifc.Expire, 0);
    chk("rst_tick", ifc.BaseTick, 0);
    rst_n      = 1'b1;
    ifc.Enable = 1'b1;

    // one-shot, period 3
    start(3, 1'b0, n);
    exp_q.push_back(n + 12);
    chk("os_busy_n", ifc.Busy, 1);
    chk("os_rem_n", ifc.Remaining, 3);
    wait_to(n + 3);
    chk("os_tick_n3", ifc.BaseTick, 0);
    wait_to(n + 4);
    chk("os_tick_n4", ifc.BaseTick, 1);
    chk("os_rem_n4", ifc.Remaining, 2);
    wait_to(n + 8);
    chk("os_rem_n8", ifc.Remaining, 1);
    wait_to(n + 11);
    chk("os_busy_n11", ifc.Busy, 1);
    wait_to(n + 12);
    chk("os_rem_n12", ifc.Remaining, 0);
    chk("os_busy_n12", ifc.Busy, 0);
    chk("os_done_n12", ifc.Done, 1);
    wait_to(n + 52);
    chk("os_done_sticky", ifc.Done, 1);
    chk("os_q_empty", exp_q.size(), 0);

    // periodic, period 2
    start(2, 1'b1, n);
    chk("pe_done_clr", ifc.Done, 0);
    exp_q.push_back(n + 8);
    exp_q.push_back(n + 16);
    exp_q.push_back(n + 24);
    wait_to(n + 8);
    chk("pe_rem_n8", ifc.Remaining, 2);
    chk("pe_busy_n8", ifc.Busy, 1);
    wait_to(n + 12);
    chk("pe_rem_n12", ifc.Remaining, 1);
    wait_to(n + 16);
    chk("pe_rem_n16", ifc.Remaining, 2);
    wait_to(n + 24);
    chk("pe_busy_n24", ifc.Busy, 1);
    stop_at(n + 27);
    chk("pe_stop_busy", ifc.Busy, 0);
    chk("pe_stop_rem", ifc.Remaining, 0);
    chk("pe_stop_done", ifc.Done, 0);
    wait_to(n + 40);
    chk("pe_q_empty", exp_q.size(), 0);

    // pause for 5 cycles from N+3
    start(2, 1'b1, n);
    exp_q.push_back(n + 13);
    wait_to(n + 2);
    ifc.Enable = 1'b0;
    wait_to(n + 5);
    chk("pa_rem_n5", ifc.Remaining, 2);
    wait_to(n + 7);
    chk("pa_rem_n7", ifc.Remaining, 2);
    ifc.Enable = 1'b1;
    wait_to(n + 8);
    chk("pa_tick_n8", ifc.BaseTick, 0);
    wait_to(n + 9);
    chk("pa_tick_n9", ifc.BaseTick, 1);
    chk("pa_rem_n9", ifc.Remaining, 1);
    wait_to(n + 13);
    chk("pa_rem_n13", ifc.Remaining, 2);
    chk("pa_busy_n13", ifc.Busy, 1);
    stop_at(n + 16);
    wait_to(n + 30);
    chk("pa_q_empty", exp_q.size(), 0);

    // Stop and Start together
    start(1, 1'b0, n);
    exp_q.push_back(n + 4);
    wait_to(n + 4);
    chk("co_done_set", ifc.Done, 1);
    @(negedge clk);
    ifc.Start  = 1'b1;
    ifc.Stop   = 1'b1;
    ifc.Period = CNT_W'(3);
    ifc.Mode   = 1'b1;
    @(negedge clk);
    ifc.Start = 1'b0;
    ifc.Stop  = 1'b0;
    chk("co_ss_busy", ifc.Busy, 0);
    chk("co_ss_rem", ifc.Remaining, 0);
    chk("co_ss_done", ifc.Done, 0);
    repeat (16) @(negedge clk);

    // Stop on the expiry wrap edge
    start(1, 1'b1, n);
    stop_at(n + 4);
    chk("co_sw_expire", ifc.Expire, 0);
    chk("co_sw_busy", ifc.Busy, 0);
    chk("co_sw_tick", ifc.BaseTick, 1);
    wait_to(n + 12);
    chk("co_sw_q_empty", exp_q.size(), 0);

    // Start with Period 0 from IDLE
    start(1, 1'b0, n);
    exp_q.push_back(n + 4);
    wait_to(n + 5);
    ifc.Start  = 1'b1;
    ifc.Period = '0;
    @(negedge clk);
    ifc.Start = 1'b0;
    chk("co_p0_busy", ifc.Busy, 0);
    chk("co_p0_done", ifc.Done, 1);
    chk("co_p0_rem", ifc.Remaining, 0);
    wait_to(n + 7);
    chk("co_p0_tick_n7", ifc.BaseTick, 0);
    wait_to(n + 8);
    chk("co_p0_tick_n8", ifc.BaseTick, 1);

    // restart with a new period
    start(3, 1'b0, n);
    wait_to(n + 1);
    ifc.Period = CNT_W'(7);
    ifc.Mode   = 1'b1;
    wait_to(n + 4);
    chk("rs_rem_n4", ifc.Remaining, 2);
    start(1, 1'b0, n2);
    exp_q.push_back(n2 + 4);
    chk("rs_start_at", n2, n + 6);
    chk("rs_rem_n6", ifc.Remaining, 1);
    wait_to(n + 10);
    chk("rs_busy_n10", ifc.Busy, 0);
    chk("rs_done_n10", ifc.Done, 1);
    wait_to(n + 30);
    chk("rs_q_empty", exp_q.size(), 0);

    // async reset mid-run
    start(5, 1'b1, n);
    wait_to(n + 3);
    #5 rst_n = 1'b0;
    #1;
    chk("ar_busy", ifc.Busy, 0);
    chk("ar_rem", ifc.Remaining, 0);
    chk("ar_done", ifc.Done, 0);
    chk("ar_tick", ifc.BaseTick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_to(r + 3);
    chk("ar_tick_r3", ifc.BaseTick, 0);
    wait_to(r + 4);
    chk("ar_tick_r4", ifc.BaseTick, 1);
    chk("ar_busy_r4", ifc.Busy, 0);
    chk("ar_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
